board_io_ctrl: RTL
==================

Name: board_io_ctrl

Overview:
- Parametrised board-level I/O front end that sits between the raw DE1 board pins and the SoC/CPU logic.
- Synchronises and debounces N_KEYS push-buttons and N_SW slide switches, and generates one-cycle press, release and change pulses.
- Drives N_DIGITS seven-segment displays from packed hex nibbles, with per-digit blank and blink.
- Replaces the bare pin list with a reusable block. Channel counts and timing are set by parameters.

Parameters:
- N_KEYS, 4, number of push-button inputs (1..32).
- N_SW, 10, number of slide-switch inputs (1..32).
- N_DIGITS, 4, number of seven-segment digits (1..8).
- SYNC_STAGES, 2, synchroniser flop depth per input (>=2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (>=1); the default is 1 ms at 50 MHz.
- BLINK_DIV, 12500000, clock cycles per blink half-period (>=1).

Ports:
- CLOCK_50  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- KEY  in  N_KEYS  raw push-buttons; active-low (0 = pressed).
- SW  in  N_SW  raw slide switches; 1 = up.
- key_level  out  N_KEYS  debounced key state; 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse on an accepted press.
- key_release  out  N_KEYS  one-cycle pulse on an accepted release.
- sw_level  out  N_SW  debounced switch state.
- sw_change  out  N_SW  one-cycle pulse on any accepted switch transition.
- hex_value  in  4*N_DIGITS  nibble i (bits 4i+3:4i) is shown on digit i.
- hex_blank  in  N_DIGITS  1 = digit i dark.
- hex_blink  in  N_DIGITS  1 = digit i blinks.
- HEX  out  7*N_DIGITS  active-low segments; digit i occupies bits 7i+6:7i, with bit 0 = segment a through bit 6 = segment g.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All synchroniser flops, debounce counters, blink counter and blink_phase are cleared to 0.
  - key_level, sw_level and all pulse outputs are 0.
  - HEX is all ones (every digit dark).
  - KEY synchronisers reset to the released value (1) so that no press pulse fires after reset.
- Synchronisers:
  - KEY is inverted before synchronisation, so the internal level is 1 = pressed.
  - Each input bit passes through its own SYNC_STAGES-deep flop chain.
- Debounce, per channel (stable register S, counter C of width clog2(DEBOUNCE_CYCLES)+1):
  - If the synced value equals S: C is set to 0.
  - Else if C == DEBOUNCE_CYCLES-1: S takes the synced value, C is set to 0, and the pulse register asserts for exactly one cycle, concurrent with S changing.
  - Else: C increments.
  - Any glitch that returns to S before the count completes clears C, and no pulse is issued.
  - Latency from a clean raw edge to the level/pulse update is SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
  - Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Pulse definitions:
  - key_press = S rises.
  - key_release = S falls.
  - sw_change = S toggles in either direction.
  - Pulses never last more than one cycle, and a pulse never repeats while the input is held.
- Blink timer:
  - A free-running counter counts 0..BLINK_DIV-1 and wraps.
  - On each wrap, blink_phase toggles.
  - The counter runs regardless of the hex_blink inputs.
- Display, per digit, registered (1-cycle latency from hex_value/hex_blank/hex_blink to HEX):
  - If hex_blank[i], or (hex_blink[i] and blink_phase==1), the digit is driven to 7'h7F.
  - Otherwise the nibble is decoded to 7 bits (bit 6..0 = g..a, active-low):
    - 0=40, 1=79, 2=24, 3=30
    - 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03
    - C=46, d=21, E=06, F=0E
  - hex_blank takes priority over hex_blink.
- Reset mid-operation:
  - Any in-flight debounce count is discarded and no pulse is emitted.
  - After release, KEY held pressed through reset produces one key_press at SYNC_STAGES + DEBOUNCE_CYCLES edges.
  - After release, SW held at 1 through reset produces one sw_change at SYNC_STAGES + DEBOUNCE_CYCLES edges.
- No combinational path from any input to any output.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BLINK_DIV=8, N_DIGITS=4):
- Reset release with KEY=4'hF and SW=0 -> all levels and pulses stay 0 for 50 cycles; HEX=28'hFFFFFFF until the first display update.
- KEY[1] driven 1->0 and held -> key_level[1] rises, with key_press[1]=1 for exactly one cycle, 6 edges after the drive; on release after 20 cycles, key_release[1] pulses once 6 edges later.
- KEY[0] glitch low for 3 cycles, then high -> no pulse and key_level[0]=0; then held low for 4+ cycles -> one press pulse.
- SW[9] and SW[0] toggled 0->1 in the same cycle -> sw_change=10'h201 for one cycle and sw_level=10'h201; later toggling only SW[0] back -> sw_change=10'h001.
- hex_value=16'hA5F0, blank=0, blink=0 -> after 1 cycle HEX = {08,12,0E,40} for digits 3..0; set hex_blank=4'b0100 -> digit 2 becomes 7F.
- hex_blink=4'b0001 with hex_value=16'h0008 -> digit 0 alternates between 00 and 7F every 8 cycles while the other digits stay at 40; assert RST_N low mid-blink -> HEX goes to all 7F immediately (asynchronously).

Source files
------------

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - DE1 board I/O front end: key/switch sync+debounce, seven-segment drive
module board_io_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int N_DIGITS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic [N_KEYS-1:0]     KEY,
  input  logic [N_SW-1:0]       SW,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  output logic [N_SW-1:0]       sw_level,
  output logic [N_SW-1:0]       sw_change,
  input  logic [4*N_DIGITS-1:0] hex_value,
  input  logic [N_DIGITS-1:0]   hex_blank,
  input  logic [N_DIGITS-1:0]   hex_blink,
  output logic [7*N_DIGITS-1:0] HEX
);

  // keys and switches share one channel vector: keys in the low bits, switches above
  localparam int N_CH = N_KEYS + N_SW;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // raw idle value per channel; keys idle high (released), which is also the inversion mask
  localparam logic [N_CH-1:0] RAW_IDLE = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] ch_level;
  logic [N_CH-1:0] stable_q;
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // synchroniser chains; raw idle reset so a released key never looks like a press after reset
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RAW_IDLE;
    end else begin
      sync_q[0] <= {SW, KEY};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // keys become 1 = pressed after the chain
  assign ch_level = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

  // per-channel debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        rise_q[c] <= 1'b0;
        fall_q[c] <= 1'b0;
        if (ch_level[c] == stable_q[c]) begin
          cnt_q[c] <= '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          stable_q[c] <= ch_level[c];
          cnt_q[c]    <= '0;
          rise_q[c]   <= ch_level[c];
          fall_q[c]   <= ~ch_level[c];
        end else begin
          cnt_q[c] <= cnt_q[c] + CW'(1);
        end
      end
    end
  end

  // free-running blink timer; phase flips on every wrap
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // registered segment drive; blank wins over blink, dark digits are all ones
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      HEX <= '1;
    end else begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (hex_blank[d] || (hex_blink[d] && blink_phase))
          HEX[7*d +: 7] <= 7'h7F;
        else
          HEX[7*d +: 7] <= seg_decode(hex_value[4*d +: 4]);
      end
    end
  end

  assign key_level   = stable_q[N_KEYS-1:0];
  assign key_press   = rise_q[N_KEYS-1:0];
  assign key_release = fall_q[N_KEYS-1:0];
  assign sw_level    = stable_q[N_CH-1:N_KEYS];
  assign sw_change   = rise_q[N_CH-1:N_KEYS] | fall_q[N_CH-1:N_KEYS];

endmodule
